// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage bus master between EXE_MEM and MEM_WB.
//
// Accepts one load/store/no-op per in_valid/in_ready handshake and performs
// single-beat AXI-Lite-style reads or writes. Load data is byte-selected and
// sign/zero-extended. Bus errors, misalignment and slave timeouts are reported
// as fault codes. The opaque in_tag sideband is returned unchanged on out_tag.
//
// Optional feature macro: MEMU_MISALIGN_SPLIT_EN
//   defined   : misaligned half/word accesses become two word beats (A, A+4)
//   undefined : misaligned accesses fault with code 2'b10, no bus activity
//
// Ports:
//   clk, reset (synchronous, active-high)
//   in_*   upstream request (valid/ready, op, addr, wdata, mask, tag)
//   out_*  downstream result (valid/ready, rdata, tag, fault, fault_code)
//   m_ar*/m_r*  read address / read data channels
//   m_aw*/m_w*/m_b*  write address / write data / write response channels
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TAG_W       = 24,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_mask,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_fault,
    output logic [1:0]        out_fault_code,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    output logic [2:0]        m_arsize,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    output logic [2:0]        m_awsize,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    output logic              m_wlast,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

`ifdef MEMU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0]  OP_LOAD  = 2'b01;
    localparam logic [1:0]  OP_STORE = 2'b10;
    localparam logic [1:0]  FC_NONE  = 2'b00;
    localparam logic [1:0]  FC_BUS   = 2'b01;
    localparam logic [1:0]  FC_ALIGN = 2'b10;
    localparam logic [1:0]  FC_TOUT  = 2'b11;
    localparam logic [2:0]  SZ_WORD  = 3'b010;
    localparam bit          TO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [31:0] TO_LAST  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                is_load_q, is_load_d, is_store_q, is_store_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, req_addr_q, req_addr_d;
    logic [2:0]          mask_q, mask_d, size_q, size_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                split_q, split_d, beat_q, beat_d;
    logic [63:0]         wimg_q, wimg_d;
    logic [7:0]          strb8_q, strb8_d;
    logic [31:0]         beat0_q, beat0_d, beat1_q, beat1_d;
    logic [1:0]          code_q, code_d;
    logic [31:0]         timer_q, timer_d;
    logic                arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                rready_q, rready_d, bready_q, bready_d;

    // Request decode
    logic [1:0] in_sz;
    logic [3:0] strb_base;
    logic       in_misalign;

    always_comb begin
        in_sz = 2'd2;
        if (in_op == OP_STORE) begin
            case (in_mask)
                3'b000:  in_sz = 2'd0;
                3'b001:  in_sz = 2'd1;
                default: in_sz = 2'd2;
            endcase
        end else begin
            case (in_mask)
                3'b000, 3'b001: in_sz = 2'd0;
                3'b010, 3'b011: in_sz = 2'd1;
                default:        in_sz = 2'd2;
            endcase
        end
        case (in_sz)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        in_misalign = ((in_sz == 2'd1) && (in_addr[1:0] == 2'b11)) ||
                      ((in_sz == 2'd2) && (in_addr[1:0] != 2'b00));
    end

    logic ar_left, aw_left, w_left, timeout_hit, r_hs, b_hs;
    logic [1:0] resp;

    assign ar_left     = arvalid_q & ~m_arready;
    assign aw_left     = awvalid_q & ~m_awready;
    assign w_left      = wvalid_q & ~m_wready;
    assign timeout_hit = TO_EN && (timer_q == TO_LAST);
    assign r_hs        = m_rvalid & rready_q;
    assign b_hs        = m_bvalid & bready_q;
    assign resp        = r_hs ? m_rresp : m_bresp;

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        req_addr_d = req_addr_q;
        mask_d     = mask_q;
        size_d     = size_q;
        tag_d      = tag_q;
        split_d    = split_q;
        beat_d     = beat_q;
        wimg_d     = wimg_q;
        strb8_d    = strb8_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        code_d     = code_q;
        timer_d    = timer_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        rready_d   = rready_q;
        bready_d   = bready_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    is_load_d  = (in_op == OP_LOAD);
                    is_store_d = (in_op == OP_STORE);
                    addr_d     = in_addr;
                    mask_d     = in_mask;
                    tag_d      = in_tag;
                    code_d     = FC_NONE;
                    beat_d     = 1'b0;
                    beat0_d    = 32'd0;
                    beat1_d    = 32'd0;
                    split_d    = 1'b0;
                    timer_d    = 32'd0;
                    if (in_op != OP_LOAD && in_op != OP_STORE) begin
                        state_d = S_DONE;
                    end else if (in_misalign && !SPLIT_EN) begin
                        code_d  = FC_ALIGN;
                        state_d = S_DONE;
                    end else begin
                        // Split accesses always use word beats on the aligned base.
                        split_d    = in_misalign;
                        size_d     = in_misalign ? SZ_WORD : {1'b0, in_sz};
                        req_addr_d = in_misalign ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;
                        wimg_d     = {32'd0, in_wdata} << {in_addr[1:0], 3'b000};
                        strb8_d    = {4'b0000, strb_base} << in_addr[1:0];
                        arvalid_d  = (in_op == OP_LOAD);
                        awvalid_d  = (in_op == OP_STORE);
                        wvalid_d   = (in_op == OP_STORE);
                        state_d    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                timer_d   = timer_q + 32'd1;
                arvalid_d = ar_left;
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (timeout_hit) begin
                    arvalid_d = 1'b0;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    code_d    = FC_TOUT;
                    state_d   = S_DONE;
                end else if (!ar_left && !aw_left && !w_left) begin
                    rready_d = is_load_q;
                    bready_d = is_store_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                timer_d = timer_q + 32'd1;
                if (r_hs || b_hs) begin
                    rready_d = 1'b0;
                    bready_d = 1'b0;
                    if (r_hs) begin
                        if (beat_q) beat1_d = m_rdata;
                        else        beat0_d = m_rdata;
                    end
                    if (resp != 2'b00) begin
                        code_d  = FC_BUS;
                        state_d = S_DONE;
                    end else if (split_q && !beat_q) begin
                        beat_d     = 1'b1;
                        req_addr_d = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                        arvalid_d  = is_load_q;
                        awvalid_d  = is_store_q;
                        wvalid_d   = is_store_q;
                        timer_d    = 32'd0;
                        state_d    = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    rready_d = 1'b0;
                    bready_d = 1'b0;
                    code_d   = FC_TOUT;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    size_d  = SZ_WORD;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            req_addr_q <= '0;
            mask_q     <= 3'd0;
            size_q     <= SZ_WORD;
            tag_q      <= '0;
            split_q    <= 1'b0;
            beat_q     <= 1'b0;
            wimg_q     <= 64'd0;
            strb8_q    <= 8'd0;
            beat0_q    <= 32'd0;
            beat1_q    <= 32'd0;
            code_q     <= FC_NONE;
            timer_q    <= 32'd0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            rready_q   <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            req_addr_q <= req_addr_d;
            mask_q     <= mask_d;
            size_q     <= size_d;
            tag_q      <= tag_d;
            split_q    <= split_d;
            beat_q     <= beat_d;
            wimg_q     <= wimg_d;
            strb8_q    <= strb8_d;
            beat0_q    <= beat0_d;
            beat1_q    <= beat1_d;
            code_q     <= code_d;
            timer_q    <= timer_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            rready_q   <= rready_d;
            bready_q   <= bready_d;
        end
    end

    // Load extraction works on registered beats only, so out_rdata cannot move
    // while the result waits in S_DONE. For unsplit accesses beat1_q is zero and
    // never reaches the selected bytes.
    logic [31:0] load_word, load_ext;

    assign load_word = 32'({beat1_q, beat0_q} >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (mask_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {24'd0, load_word[7:0]};
            3'b010:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b011:  load_ext = {16'd0, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    assign in_ready       = (state_q == S_IDLE);
    assign out_valid      = (state_q == S_DONE);
    assign out_rdata      = (is_load_q && code_q == FC_NONE) ? load_ext : 32'd0;
    assign out_tag        = tag_q;
    assign out_fault      = (code_q != FC_NONE);
    assign out_fault_code = code_q;

    assign m_araddr  = req_addr_q;
    assign m_arvalid = arvalid_q;
    assign m_arsize  = size_q;
    assign m_rready  = rready_q;
    assign m_awaddr  = req_addr_q;
    assign m_awvalid = awvalid_q;
    assign m_awsize  = size_q;
    assign m_wdata   = beat_q ? wimg_q[63:32] : wimg_q[31:0];
    assign m_wstrb   = beat_q ? strb8_q[7:4] : strb8_q[3:0];
    assign m_wvalid  = wvalid_q;
    assign m_wlast   = wvalid_q;
    assign m_bready  = bready_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYC = 8). Expected results are
// queued when a request is driven and compared when out_valid appears.
module tb_mem_access_unit;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic [2:0]        in_mask;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid, out_ready;
    logic [31:0]       out_rdata;
    logic [TAG_W-1:0]  out_tag;
    logic              out_fault;
    logic [1:0]        out_fault_code;
    logic [ADDR_W-1:0] m_araddr, m_awaddr;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [2:0]        m_arsize, m_awsize;
    logic [31:0]       m_rdata, m_wdata;
    logic [1:0]        m_rresp, m_bresp;
    logic              m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic [3:0]        m_wstrb;
    logic              m_bvalid, m_bready;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_mask(in_mask), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_tag(out_tag), .out_fault(out_fault), .out_fault_code(out_fault_code),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arsize(m_arsize), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awsize(m_awsize), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    typedef struct {
        logic [31:0]      rdata;
        logic [TAG_W-1:0] tag;
        logic [1:0]       code;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] mask, input logic [TAG_W-1:0] tag,
                        input logic [31:0] e_rdata, input logic [1:0] e_code);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        check("in_ready_before_req", 64'(in_ready), 64'd1);
        e.rdata = e_rdata;
        e.tag   = tag;
        e.code  = e_code;
        sb_q.push_back(e);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_mask = mask; in_tag = tag;
        step();
        in_valid = 1'b0;
        $display("req op=%0d addr=0x%08h wdata=0x%08h mask=%0d tag=0x%06h", op, addr, wd, mask, tag);
    endtask

    task automatic ar_accept(input logic [31:0] e_addr, input logic [2:0] e_size);
        int n = 0;
        while (!m_arvalid && n < 20) begin step(); n++; end
        check("arvalid", 64'(m_arvalid), 64'd1);
        check("araddr", 64'(m_araddr), 64'(e_addr));
        check("arsize", 64'(m_arsize), 64'(e_size));
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
    endtask

    task automatic r_respond(input logic [31:0] data, input logic [1:0] rsp);
        int n = 0;
        while (!m_rready && n < 20) begin step(); n++; end
        check("rready", 64'(m_rready), 64'd1);
        m_rvalid = 1'b1; m_rdata = data; m_rresp = rsp;
        step();
        m_rvalid = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        check("out_valid", 64'(out_valid), 64'd1);
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=out_valid expected=no_output");
        end else begin
            e = sb_q.pop_front();
            check("out_rdata", 64'(out_rdata), 64'(e.rdata));
            check("out_tag", 64'(out_tag), 64'(e.tag));
            check("out_fault_code", 64'(out_fault_code), 64'(e.code));
            check("out_fault", 64'(out_fault), 64'(e.code != 2'b00));
            $display("rsp rdata=0x%08h tag=0x%06h code=%0d", out_rdata, out_tag, out_fault_code);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_after_done", 64'({in_ready, out_valid}), 64'b10);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_m_valids"}, 64'({m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready}), 64'd0);
        check({pfx, "_wstrb"}, 64'(m_wstrb), 64'd0);
        check({pfx, "_sizes"}, 64'({m_arsize, m_awsize}), 64'(6'b010_010));
        check({pfx, "_outs"}, 64'({out_rdata, out_tag, out_fault_code}), 64'd0);
    endtask

    initial begin
        int   n;
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_addr = '0; in_wdata = '0;
        in_mask = 3'd0; in_tag = '0; out_ready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_state("reset");

        // LB at byte 3: sign-extended 0x80
        send(2'b01, 32'h8000_0003, 32'h0, 3'b000, 24'h00_0001, 32'hFFFF_FF80, 2'b00);
        ar_accept(32'h8000_0003, 3'd0);
        r_respond(32'h80AA_BBCC, 2'b00);
        collect();

        // SH to upper half, awready two cycles after wready
        send(2'b10, 32'h8000_0002, 32'h1234_ABCD, 3'b001, 24'h00_0002, 32'h0, 2'b00);
        check("sh_aw_w_last", 64'({m_awvalid, m_wvalid, m_wlast}), 64'b111);
        check("sh_awaddr", 64'(m_awaddr), 64'h8000_0002);
        check("sh_awsize", 64'(m_awsize), 64'd1);
        check("sh_wdata", 64'(m_wdata), 64'hABCD_0000);
        check("sh_wstrb", 64'(m_wstrb), 64'b1100);
        m_wready = 1'b1;
        step();
        m_wready = 1'b0;
        check("sh_after_w", 64'({m_awvalid, m_wvalid, m_bready}), 64'b100);
        step();
        check("sh_bready_wait", 64'(m_bready), 64'd0);
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
        check("sh_after_aw", 64'({m_awvalid, m_bready}), 64'b01);
        m_bvalid = 1'b1; m_bresp = 2'b00;
        step();
        m_bvalid = 1'b0;
        check("sh_out_valid_1cyc", 64'({out_valid, m_bready}), 64'b10);
        collect();

        // LH at byte 1: sign-extended 0x8FE0
        send(2'b01, 32'h8000_0001, 32'h0, 3'b010, 24'h00_0003, 32'hFFFF_8FE0, 2'b00);
        ar_accept(32'h8000_0001, 3'd1);
        r_respond(32'h128F_E034, 2'b00);
        collect();

        // LW with SLVERR
        send(2'b01, 32'h8000_0010, 32'h0, 3'b100, 24'hABC123, 32'h0, 2'b01);
        ar_accept(32'h8000_0010, 3'd2);
        r_respond(32'h5555_AAAA, 2'b10);
        collect();

        // Hung slave: timeout 8 cycles after arvalid rises
        send(2'b01, 32'h8000_0020, 32'h0, 3'b100, 24'h00_0005, 32'h0, 2'b11);
        check("to_arvalid", 64'(m_arvalid), 64'd1);
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        check("to_latency", 64'(n), 64'd8);
        check("to_bus_idle", 64'({m_arvalid, m_rready}), 64'b00);
        collect();

        // LHU straddling a word boundary
`ifdef MEMU_MISALIGN_SPLIT_EN
        send(2'b01, 32'h8000_0003, 32'h0, 3'b011, 24'h00_0006, 32'h0000_8811, 2'b00);
        ar_accept(32'h8000_0000, 3'd2);
        r_respond(32'h1122_3344, 2'b00);
        ar_accept(32'h8000_0004, 3'd2);
        r_respond(32'h5566_7788, 2'b00);
        collect();
`else
        send(2'b01, 32'h8000_0003, 32'h0, 3'b011, 24'h00_0006, 32'h0, 2'b10);
        check("mis_ld_no_ar", 64'({m_arvalid, out_valid}), 64'b01);
        collect();
        send(2'b10, 32'h8000_0001, 32'hCAFE_F00D, 3'b010, 24'h00_0007, 32'h0, 2'b10);
        check("mis_st_no_aw", 64'({m_awvalid, m_wvalid, out_valid}), 64'b001);
        collect();
`endif

        // op 11 behaves as no-op: done one cycle after acceptance
        send(2'b11, 32'h8000_0050, 32'h0, 3'b100, 24'h00_0008, 32'h0, 2'b00);
        check("nop_latency", 64'({out_valid, m_arvalid, m_awvalid}), 64'b100);
        collect();

        // Result held with out_ready low, then reset abandons it
        send(2'b01, 32'h8000_0040, 32'h0, 3'b100, 24'h00_0009, 32'hDEAD_BEEF, 2'b00);
        ar_accept(32'h8000_0040, 3'd2);
        r_respond(32'hDEAD_BEEF, 2'b00);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_rdata", 64'(out_rdata), 64'(e.rdata));
            check("hold_tag_code", 64'({out_tag, out_fault_code}), 64'({e.tag, e.code}));
            step();
        end
        $display("rsp held rdata=0x%08h tag=0x%06h, reset applied", out_rdata, out_tag);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_state("midreset");
        step();
        check("post_reset_idle", 64'({in_ready, out_valid}), 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline's single-request MEM-stage AXI master; sits between EXE_MEM and MEM_WB.
- Accepts one load/store/no-op per valid/ready handshake and issues AXI-Lite-style transactions (len 0).
- Sign/zero-extends load data, reports bus errors, misalignment and slave timeouts as faults, and carries an opaque sideband tag to the writeback side.

Parameters:
- ADDR_W, 32, address width.
- TAG_W, 24, width of the opaque sideband (rd index, write enables, csr data, etc.) passed through unchanged.
- TIMEOUT_CYC, 255, cycles allowed per beat from issue to response before a timeout fault; 0 disables the timer.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream request valid
- in_ready  out  1  high only in S_IDLE
- in_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- in_addr  in  ADDR_W  effective address
- in_wdata  in  32  store data, right-aligned
- in_mask  in  3  load: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; store: 000 SB, 001 SH, 010 SW
- in_tag  in  TAG_W  sideband
- out_valid  out  1  high only in S_DONE
- out_ready  in  1  downstream ready
- out_rdata  out  32  extended load data; 0 for store/none/fault
- out_tag  out  TAG_W  registered in_tag
- out_fault  out  1  request faulted
- out_fault_code  out  2  00 none, 01 bus error (resp!=0), 10 misaligned, 11 timeout
- m_araddr/m_arvalid/m_arsize  out  ADDR_W/1/3; m_arready in 1
- m_rdata/m_rresp/m_rvalid  in  32/2/1; m_rready out 1
- m_awaddr/m_awvalid/m_awsize  out  ADDR_W/1/3; m_awready in 1
- m_wdata/m_wstrb/m_wvalid/m_wlast  out  32/4/1/1; m_wready in 1
- m_bresp/m_bvalid  in  2/1; m_bready out 1

Behaviour:
- Reset: state S_IDLE; all m_*valid, m_rready, m_bready, m_wlast = 0; m_wstrb = 0; m_arsize/m_awsize = 3'b010; out_rdata, out_tag, out_fault_code = 0; beat counter and timer = 0.
- States: S_IDLE, S_ADDR, S_RESP, S_DONE.
- S_IDLE, on in_valid & in_ready:
  - Latch op, addr, wdata, mask, tag.
  - op none -> S_DONE next cycle (latency 1).
  - Misaligned (half with addr[1:0]==3, word with addr[1:0]!=0) and split disabled -> S_DONE with code 10; no bus activity.
  - Otherwise raise arvalid, or awvalid+wvalid+wlast together, -> S_ADDR.
- Single-beat sizing: arsize/awsize = 0/1/2 for byte/half/word.
- Store lanes: wdata = in_wdata << 8*addr[1:0]; wstrb = 0001/0011/1111 shifted left by addr[1:0].
- S_ADDR:
  - Each valid drops on its own handshake; aw and w may complete in either order or the same cycle.
  - When all valids are low, raise rready/bready -> S_RESP.
- S_RESP, on rvalid&rready or bvalid&bready:
  - Drop ready and capture data.
  - resp!=0 -> code 01, S_DONE.
  - Else if a second split beat remains, issue it -> S_ADDR.
  - Else S_DONE.
- Load data:
  - byte = word >> 8*addr[1:0]; half = bits[15:0] of the same shift.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Extension is computed from registered beats; out_rdata is stable throughout S_DONE.
- Timer:
  - Counts every cycle in S_ADDR/S_RESP; clears on entry to S_ADDR for each beat.
  - Reaching TIMEOUT_CYC forces all m_*valid/ready low, code 11, S_DONE.
  - This is a documented non-compliant recovery path for hung slaves.
- S_DONE: out_valid=1; all outputs held stable until out_ready; then S_IDLE with sizes restored to 3'b010.
- Back-to-back: a new request is accepted the cycle after the S_DONE handshake; no combinational in_valid->out_valid path.
- A reset asserted mid-transaction abandons it immediately; no response is generated and all outputs return to reset values.

Optional Feature:
- Macro MEMU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses become two word-sized (size 2) beats at A=addr&~3 and A+4.
  - Stores: 64-bit lane image {32'b0,wdata} << 8*addr[1:0]; beat 0 uses low word and wstrb[3:0] of the 8-bit strobe, beat 1 uses high word and strobe[7:4].
  - Loads: {beat1,beat0} >> 8*addr[1:0] before extension.
  - A fault on beat 0 aborts beat 1.
- Undefined: misaligned requests fault with code 10 and issue no bus activity.

Test Plan:
- LB at 0x8000_0003, slave returns 0x80AA_BBCC -> araddr 0x8000_0003, arsize 0; out_rdata 0xFFFF_FF80; code 00.
- SH 0x1234_ABCD at 0x8000_0002, slave asserts awready 2 cycles after wready -> wdata 0xABCD_0000, wstrb 1100, awsize 1; bready rises only after both handshakes; out_valid 1 cycle after bvalid.
- LW at 0x8000_0010 with rresp=2'b10 -> out_fault=1, code 01, out_rdata 0; out_tag equals the input tag.
- No response with TIMEOUT_CYC=8 -> out_valid 8 cycles after arvalid; code 11; arvalid/rready low.
- LHU at 0x8000_0003, beat0 0x11_22_33_44, beat1 0x55_66_77_88 -> with split enabled: two ARs (0x8000_0000, 0x8000_0004), out_rdata 0x0000_8811; without split: code 10, no AR.
- out_ready held low 5 cycles in S_DONE, then reset asserted -> outputs stable while waiting; after reset out_valid=0, in_ready=1, all m_*valid=0.
